// File: rtl/dmem_responder.sv
// Word-organised data RAM answering RV32I load/store requests after a fixed latency.
// Requests are latched in IDLE, committed LATENCY edges later, and held in RESP until taken.
module dmem_responder #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DEPTH_WORDS = 1024,
  parameter int unsigned           LATENCY     = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef logic [ADDR_WIDTH:0] aext_t;

  localparam aext_t      BASE_EXT = aext_t'(BASE_ADDR);
  localparam aext_t      SPAN     = aext_t'(4 * DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;
  logic                    resp_err_q;

  logic                    we_q;
  logic [2:0]              f3_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

  logic                    accept;
  logic                    commit;
  aext_t                   off;
  logic [IDX_W-1:0]        idx;
  logic                    in_range;
  logic                    legal_f3;
  logic                    misaligned;
  logic                    err_d;
  logic [DATA_WIDTH-1:0]   word;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   load_d;
  logic [DATA_WIDTH-1:0]   rdata_d;
  logic [3:0]              be_d;
  logic [DATA_WIDTH-1:0]   wlane_d;

  assign accept = (state_q == IDLE) && req_ready_q && req_valid;
  assign commit = (state_q == BUSY) && (cnt_q == 4'd0);

  // Address decode: the offset is only meaningful once addr_q >= BASE_ADDR, which in_range guards.
  always_comb begin
    off      = aext_t'(addr_q) - BASE_EXT;
    idx      = off[IDX_W+1:2];
    in_range = (aext_t'(addr_q) >= BASE_EXT) && (off < SPAN);
  end

  always_comb begin
    if (we_q) begin
      legal_f3 = f3_q inside {3'd0, 3'd1, 3'd2};
    end else begin
      legal_f3 = f3_q inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    end
    misaligned = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                 ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    err_d      = !in_range || !legal_f3 || misaligned;
  end

  // Aligned accesses let one byte-granular shift serve every load width.
  always_comb begin
    word    = mem_q[idx];
    shifted = word >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'd0:    load_d = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_d = {{16{shifted[15]}}, shifted[15:0]};
      3'd2:    load_d = shifted;
      3'd4:    load_d = {24'd0, shifted[7:0]};
      3'd5:    load_d = {16'd0, shifted[15:0]};
      default: load_d = '0;
    endcase
    rdata_d = (we_q || err_d) ? '0 : load_d;
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr_q[1:0];
        wlane_d = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_d    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane_d = {2{wdata_q[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wlane_d = wdata_q;
      end
    endcase
  end

  // Request capture and RAM write carry no reset; a store only lands on a BUSY commit edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if (commit && we_q && !err_d) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) begin
          mem_q[idx][8*b +: 8] <= wlane_d[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= BUSY;
            cnt_q       <= CNT_INIT;
            req_ready_q <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rdata_d;
            resp_err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand sequences for hold and reset,
// and randomized accesses checked against a byte-array reference model.
module tb_dmem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [4*DEPTH];

  dmem_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: RAM as a flat byte array, results derived from access size and signedness.
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output bit err);
    int     size;
    longint off;
    longint v;
    bit     legal;
    rd  = '0;
    err = 1'b0;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
    off   = longint'(addr) - longint'(BASE);
    if (!legal || off < 0 || off >= 4 * DEPTH || (addr % size) != 0) begin
      err = 1'b1;
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_mem[int'(off) + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v += longint'(ref_mem[int'(off) + i]) << (8 * i);
      if (f3 < 3'd4 && size < 4 && v >= (64'sd1 << (8 * size - 1))) v -= (64'sd1 << (8 * size));
      rd = v[31:0];
    end
  endtask

  // Entered and left at posedge+1; checks handshake timing, hold stability and turnaround.
  task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int hold, input string tag,
                           output logic [31:0] rd, output bit err);
    bit ok;
    int lat;
    rd  = '0;
    err = 1'b1;
    ok  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin timeout_fail({tag, "_req_ready"}); return; end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_addr   = $urandom();
    req_wdata  = $urandom();
    check({tag, "_busy_req_ready"}, 32'(req_ready), 32'd0);
    ok  = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (resp_valid) begin lat = i; ok = 1'b1; break; end
    end
    if (!ok) begin timeout_fail({tag, "_resp_valid"}); return; end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    rd  = resp_rdata;
    err = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_hold_rdata"}, resp_rdata, rd);
      check({tag, "_hold_err"}, 32'(resp_err), 32'(err));
      check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_post_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] rd, exp_rd;
    bit          err, exp_err;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    int          r;

    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int w = 0; w < 16; w++) begin
      model(1'b1, 3'd2, BASE + 32'(4 * w), 32'd0, exp_rd, exp_err);
      do_access(1'b1, 3'd2, BASE + 32'(4 * w), 32'd0, 0, "init", rd, err);
      check("init_err", 32'(err), 32'd0);
    end

    tbl.push_back('{1'b1, 3'd2, 32'h0001_0004, 32'hDEADBEEF, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h0001_0004, 32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b0, 3'd0, 32'h0001_0007, 32'h0,        32'hFFFFFFDE, 1'b0});
    tbl.push_back('{1'b0, 3'd4, 32'h0001_0007, 32'h0,        32'h000000DE, 1'b0});
    tbl.push_back('{1'b0, 3'd1, 32'h0001_0006, 32'h0,        32'hFFFFDEAD, 1'b0});
    tbl.push_back('{1'b0, 3'd5, 32'h0001_0004, 32'h0,        32'h0000BEEF, 1'b0});
    tbl.push_back('{1'b1, 3'd0, 32'h0001_0005, 32'h12,       32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h0001_0004, 32'h0,        32'hDEAD12EF, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h0001_0002, 32'h0,        32'h0000_0000, 1'b1});
    tbl.push_back('{1'b1, 3'd1, 32'h0001_0003, 32'hABCD,     32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 3'd2, 32'h0000_FFFC, 32'h0,        32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 3'd2, 32'h0001_1000, 32'h0,        32'h0000_0000, 1'b1});
    tbl.push_back('{1'b1, 3'd2, 32'h0001_1000, 32'h5A5A5A5A, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 3'd3, 32'h0001_0000, 32'h0,        32'h0000_0000, 1'b1});
    tbl.push_back('{1'b1, 3'd4, 32'h0001_0000, 32'h77777777, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 3'd2, 32'h0001_0004, 32'h0,        32'hDEAD12EF, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h0001_0000, 32'h0,        32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 3'd2, 32'h0001_0FFC, 32'hCAFEF00D, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h0001_0FFC, 32'h0,        32'hCAFEF00D, 1'b0});
    tbl.push_back('{1'b1, 3'd1, 32'h0001_0006, 32'h5555,     32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h0001_0004, 32'h0,        32'h555512EF, 1'b0});
    tbl.push_back('{1'b0, 3'd1, 32'h0001_0004, 32'h0,        32'h000012EF, 1'b0});

    foreach (tbl[i]) begin
      model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, exp_rd, exp_err);
      do_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, 0, "vec", rd, err);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].err));
    end

    do_access(1'b0, 3'd2, 32'h0001_0004, 32'h0, 5, "hold", rd, err);
    check("hold_rdata", rd, 32'h555512EF);
    check("hold_err", 32'(err), 32'd0);

    // Store aborted by reset while BUSY must leave the old zero in place.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h0001_0008;
    req_wdata  = 32'h11111111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_busy_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_held_valid", 32'(resp_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 3'd2, 32'h0001_0008, 32'h0, 0, "rst_load", rd, err);
    check("rst_load_rdata", rd, 32'h0000_0000);
    check("rst_load_err", 32'(err), 32'd0);

    for (int it = 0; it < 150; it++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      r  = int'($urandom_range(0, 9));
      if (r == 0)      addr = BASE - 32'($urandom_range(1, 8));
      else if (r == 1) addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
      else             addr = BASE + 32'($urandom_range(0, 63));
      wd = $urandom();
      model(we, f3, addr, wd, exp_rd, exp_err);
      do_access(we, f3, addr, wd, int'($urandom_range(0, 2)), "rand", rd, err);
      check($sformatf("rand%0d_rdata", it), rd, exp_rd);
      check($sformatf("rand%0d_err", it), 32'(err), 32'(exp_err));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
